// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit in front of a word-wide data memory without byte enables.
// Loads are lane-selected and extended into a register; sb/sh use a two-cycle read-modify-write.
module mem_access_unit #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        Funct3,
    input  logic [31:0]       ByteAddress,
    input  logic [31:0]       StoreData,
    output logic [ADDR_W-1:0] DataAddress,
    output logic              DataMemRead,
    output logic              DataMemWrite,
    output logic [31:0]       DataInput,
    input  logic [31:0]       DataOutput,
    output logic [31:0]       LoadData,
    output logic              LoadValid,
    output logic              AccessFault,
    output logic              Stall,
    output logic              fsm_state
);

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [31:0]       rmw_word;
    logic [ADDR_W-1:0] rmw_addr;

    logic [1:0]        lane;
    logic [4:0]        shift;
    logic [ADDR_W-1:0] word_addr;
    logic              aligned;
    logic              store_legal;
    logic              load_legal;
    logic [31:0]       rd_shifted;
    logic [31:0]       load_ext;
    logic [31:0]       lane_mask;
    logic [31:0]       merged;
    logic              load_capture;
    logic              rmw_capture;
    logic              fault_now;
    logic              unused_addr_bits;

    assign lane             = ByteAddress[1:0];
    assign shift            = {lane, 3'b000};
    assign word_addr        = ByteAddress[ADDR_W+1:2];
    assign unused_addr_bits = ^ByteAddress[31:ADDR_W+2];
    assign fsm_state        = (state == RMW_WR);

    // Funct3[1:0] encodes access size for both loads and stores.
    always_comb begin
        aligned = 1'b0;
        case (Funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~lane[0];
            2'b10:   aligned = (lane == 2'b00);
            default: aligned = 1'b0;
        endcase
    end

    assign store_legal = aligned && (Funct3 == 3'b000 || Funct3 == 3'b001 || Funct3 == 3'b010);
    assign load_legal  = aligned && (Funct3 == 3'b000 || Funct3 == 3'b001 || Funct3 == 3'b010 ||
                                     Funct3 == 3'b100 || Funct3 == 3'b101);

    assign rd_shifted = DataOutput >> shift;

    always_comb begin
        load_ext = DataOutput;
        case (Funct3)
            3'b000:  load_ext = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            3'b001:  load_ext = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            3'b100:  load_ext = {24'h0, rd_shifted[7:0]};
            3'b101:  load_ext = {16'h0, rd_shifted[15:0]};
            default: load_ext = DataOutput;
        endcase
    end

    assign lane_mask = (Funct3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << shift;
    assign merged    = (DataOutput & ~lane_mask) | ((StoreData << shift) & lane_mask);

    // Stall is the only back-pressure: while it is high, EX/MEM presents the same
    // request again next cycle, so RMW_WR may ignore the inputs entirely.
    always_comb begin
        state_next   = state;
        DataAddress  = word_addr;
        DataMemRead  = 1'b0;
        DataMemWrite = 1'b0;
        DataInput    = 32'h0;
        Stall        = 1'b0;
        load_capture = 1'b0;
        rmw_capture  = 1'b0;
        fault_now    = 1'b0;
        case (state)
            IDLE: begin
                if (MemWrite) begin
                    if (!store_legal) begin
                        fault_now = 1'b1;
                    end else if (Funct3 == 3'b010) begin
                        DataMemWrite = 1'b1;
                        DataInput    = StoreData;
                    end else begin
                        DataMemRead = 1'b1;
                        Stall       = 1'b1;
                        rmw_capture = 1'b1;
                        state_next  = RMW_WR;
                    end
                end else if (MemRead) begin
                    if (load_legal) begin
                        DataMemRead  = 1'b1;
                        load_capture = 1'b1;
                    end else begin
                        fault_now = 1'b1;
                    end
                end
            end
            RMW_WR: begin
                DataAddress  = rmw_addr;
                DataMemWrite = 1'b1;
                DataInput    = rmw_word;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // A reset landing in RMW_WR must not let the pending write escape.
        if (reset) begin
            DataMemRead  = 1'b0;
            DataMemWrite = 1'b0;
            DataInput    = 32'h0;
            Stall        = 1'b0;
            load_capture = 1'b0;
            rmw_capture  = 1'b0;
            fault_now    = 1'b0;
            state_next   = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            LoadData    <= 32'h0;
            LoadValid   <= 1'b0;
            AccessFault <= 1'b0;
            rmw_word    <= 32'h0;
            rmw_addr    <= '0;
        end else begin
            state       <= state_next;
            LoadValid   <= load_capture;
            AccessFault <= fault_now;
            if (load_capture) begin
                LoadData <= load_ext;
            end
            if (rmw_capture) begin
                rmw_word <= merged;
                rmw_addr <= word_addr;
            end
        end
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store access unit sitting in the MEM stage directly upstream of the word-wide data memory. It converts RV32I byte-addressed loads and stores into word accesses on the memory's 7-bit word address. Loads are sign- or zero-extended and registered toward write-back; sub-word stores use a two-cycle read-modify-write because the memory has no byte enables. Misaligned and illegal accesses are blocked and reported.

## Interface
- ADDR_W, 7, word-address width of the data memory; byte address bits [ADDR_W+1:2] are used.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- MemRead  in  1  load request from EX/MEM
- MemWrite  in  1  store request from EX/MEM; wins over MemRead if both are high
- Funct3  in  3  RV32I width code: 000 b, 001 h, 010 w, 100 bu, 101 hu
- ByteAddress  in  32  ALU result (byte address)
- StoreData  in  32  rs2 value
- DataAddress  out  ADDR_W  word address to memory
- DataMemRead  out  1  memory read strobe
- DataMemWrite  out  1  memory write strobe
- DataInput  out  32  write word to memory
- DataOutput  in  32  read word from memory (combinational)
- LoadData  out  32  registered, extended load result
- LoadValid  out  1  one-cycle pulse: LoadData updated
- AccessFault  out  1  one-cycle registered pulse: misaligned or illegal access blocked
- Stall  out  1  combinational; pipeline must hold EX/MEM contents this cycle

## Operation
- Lane order is little-endian: ByteAddress[1:0]=0 selects bits [7:0]. DataAddress = ByteAddress[ADDR_W+1:2]; upper bits are ignored, so addresses wrap.
- Legality rules:
  - w requires [1:0]=00; h/hu require [0]=0; b/bu are always aligned.
  - Stores accept only 000/001/010; every other Funct3 is illegal.
  - An illegal or misaligned request drives no strobe and gives AccessFault=1 next cycle. LoadValid stays 0 and LoadData holds its value.
- FSM states: IDLE, RMW_WR.
- IDLE with a load:
  - DataMemRead=1.
  - The selected byte/half is sign-extended (b, h) or zero-extended (bu, hu) and registered into LoadData, with LoadValid=1 next cycle.
- IDLE with sw: DataMemWrite=1 and DataInput=StoreData in the same cycle; single cycle.
- IDLE with sb/sh, first cycle:
  - DataMemRead=1 and Stall=1.
  - DataOutput is merged with StoreData[7:0] or [15:0] in the addressed lane.
  - The merged word and DataAddress are latched, then the FSM moves to RMW_WR.
- RMW_WR, second cycle:
  - DataMemWrite=1 and DataInput = latched word at the latched address; Stall=0.
  - Inputs are ignored this cycle (they still hold the same instruction). The FSM returns to IDLE.
- No request in IDLE: all strobes are 0 and DataInput=0.

## Timing
- Reset values: state IDLE, LoadData 0, LoadValid 0, AccessFault 0, latched word and address 0. While reset is high, DataMemRead, DataMemWrite and Stall are forced to 0.
- Latency:
  - Load: the result is visible in LoadData 1 cycle after request.
  - sw: 1 cycle, zero stall.
  - sb/sh: 2 cycles with exactly one stall cycle.
- Stall is high only in the IDLE cycle that accepts a legal sb/sh. It is never high in RMW_WR, and never high for faults.
- Reset asserted in RMW_WR aborts the write: no DataMemWrite is issued and the FSM is IDLE after reset.
- Back-to-back sb to the same word: the second RMW reads the memory after the first write has completed, so both bytes survive.
- LoadValid and AccessFault are never high in the same cycle.

## Test plan
- Memory word 5 = 0x8070_60F0. lb from 0x14 -> LoadData 0xFFFF_FFF0; lbu from 0x14 -> 0x0000_00F0; lh from 0x16 -> 0xFFFF_8070; LoadValid pulses each time.
- Word 5 = 0x1122_3344. sb 0xAB to 0x15 -> Stall high for one cycle, then DataMemWrite with DataInput 0x1122_AB44 at DataAddress 5.
- sh 0xBEEF to 0x1A, then immediately sb 0x77 to 0x18 -> word 6 ends as 0xBEEF_xx77 (the two low-byte positions, bits [15:8], retain their prior value).
- lw from 0x13, sh to 0x11, and Funct3 011 store -> AccessFault pulses each time; no strobes; LoadData unchanged.
- sw 0xDEAD_BEEF to 0x200 with ADDR_W=7 -> DataAddress 0 (wrap), single-cycle write, Stall stays 0.
- Reset asserted during RMW_WR of an sb -> DataMemWrite never asserts; memory word unchanged; all outputs 0.
